// File: rtl/controle_lampada.sv
// Lamp controller: debounces the wall button, classifies short/long presses and
// runs the AUTO/MANUAL lamp FSM that also arms the auto-shutdown timer.
module controle_lampada #(
  parameter int unsigned DEBOUNCE_T   = 100,
  parameter int unsigned LONG_PRESS_T = 3000
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  input  logic infravermelho,
  input  logic C,
  output logic lamp,
  output logic enable,
  output logic manual
);

  localparam logic [1:0] AUTO_OFF   = 2'd0;
  localparam logic [1:0] AUTO_ON    = 2'd1;
  localparam logic [1:0] MANUAL_OFF = 2'd2;
  localparam logic [1:0] MANUAL_ON  = 2'd3;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_T - 1);
  localparam logic [15:0] LP_MAX  = 16'(LONG_PRESS_T);
  localparam logic [15:0] LP_LAST = 16'(LONG_PRESS_T - 1);

  logic [1:0]  state_q, state_d;
  logic        btn_s_q, btn_s_d;
  logic        db_q, db_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tp_q, tp_d;
  logic        long_press_q, long_press_d;
  logic        short_press_q, short_press_d;
  logic        ir_prev_q, ir_prev_d;
  logic        ir_rise;

  always_comb begin
    btn_s_d = push_button;
    db_d    = db_q;
    cnt_d   = 16'd0;
    if (btn_s_q != db_q) begin
      if (cnt_q == DB_LAST) begin
        db_d  = btn_s_q;
        cnt_d = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    // Tp saturates, so a long press fires once per hold and suppresses the release pulse
    tp_d = tp_q;
    if (db_d && !db_q) begin
      tp_d = 16'd0;
    end else if (db_q && (tp_q < LP_MAX)) begin
      tp_d = tp_q + 16'd1;
    end
    long_press_d  = db_q & db_d & (tp_q == LP_LAST);
    short_press_d = db_q & ~db_d & (tp_q < LP_MAX);

    ir_prev_d = infravermelho;
    ir_rise   = infravermelho & ~ir_prev_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      AUTO_OFF: begin
        if (long_press_q)       state_d = MANUAL_OFF;
        else if (short_press_q) state_d = AUTO_ON;
        else if (ir_rise)       state_d = AUTO_ON;
      end
      AUTO_ON: begin
        if (long_press_q)       state_d = MANUAL_ON;
        else if (short_press_q) state_d = AUTO_OFF;
        else if (C)             state_d = AUTO_OFF;
      end
      MANUAL_OFF: begin
        if (long_press_q)       state_d = AUTO_OFF;
        else if (short_press_q) state_d = MANUAL_ON;
      end
      MANUAL_ON: begin
        if (long_press_q)       state_d = AUTO_ON;
        else if (short_press_q) state_d = MANUAL_OFF;
      end
      default: state_d = AUTO_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= AUTO_OFF;
      btn_s_q       <= 1'b0;
      db_q          <= 1'b0;
      cnt_q         <= 16'd0;
      tp_q          <= 16'd0;
      long_press_q  <= 1'b0;
      short_press_q <= 1'b0;
      ir_prev_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      btn_s_q       <= btn_s_d;
      db_q          <= db_d;
      cnt_q         <= cnt_d;
      tp_q          <= tp_d;
      long_press_q  <= long_press_d;
      short_press_q <= short_press_d;
      ir_prev_q     <= ir_prev_d;
    end
  end

  assign lamp   = (state_q == AUTO_ON) || (state_q == MANUAL_ON);
  assign manual = (state_q == MANUAL_OFF) || (state_q == MANUAL_ON);
  assign enable = (state_q == AUTO_ON);

endmodule

// File: tb/tb_controle_lampada.sv
// Bench for controle_lampada: directed scenarios plus random traffic, every cycle's
// outputs predicted by a mode/lamp reference model and checked through a scoreboard queue.
module tb_controle_lampada;

  localparam int DT = 4;
  localparam int LT = 20;

  logic clk = 1'b0;
  logic rst, push_button, infravermelho, C;
  logic lamp, enable, manual;

  always #5 clk = ~clk;

  controle_lampada #(.DEBOUNCE_T(DT), .LONG_PRESS_T(LT)) dut (
    .clk(clk), .rst(rst), .push_button(push_button), .infravermelho(infravermelho),
    .C(C), .lamp(lamp), .enable(enable), .manual(manual)
  );

  logic [2:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  bit done = 0;

  // Reference model: button sampler, sliding-window debouncer, hold-length tracker,
  // and the lamp expressed as (manual mode, lamp on) rather than named states.
  bit m_btn_s, m_db, m_ir_prev, m_lp, m_sp, m_manual, m_lamp;
  bit win[$];
  int m_held;
  bit pb_lvl, ir_lvl;

  task automatic model_reset();
    m_btn_s = 0; m_db = 0; m_ir_prev = 0; m_lp = 0; m_sp = 0;
    m_manual = 0; m_lamp = 0; m_held = 0;
    win.delete();
    for (int i = 0; i < DT; i++) win.push_back(1'b0);
  endtask

  task automatic model_edge(input bit r, input bit pb, input bit ir, input bit c);
    bit flip, new_db, rise;
    if (r) begin
      model_reset();
      return;
    end
    rise = ir & ~m_ir_prev;
    if (m_lp) m_manual = ~m_manual;
    else if (m_sp) m_lamp = ~m_lamp;
    else if (!m_manual && m_lamp && c) m_lamp = 0;
    else if (!m_manual && !m_lamp && rise) m_lamp = 1;
    // level accepted once the last DT sampled values all disagree with it
    win.push_back(m_btn_s);
    void'(win.pop_front());
    flip = 1;
    foreach (win[i]) if (win[i] == m_db) flip = 0;
    new_db = flip ? ~m_db : m_db;
    m_lp = 0;
    m_sp = 0;
    if (m_db && !new_db) m_sp = (m_held < LT);
    if (!m_db && new_db) m_held = 0;
    else if (m_db) begin
      if (new_db && m_held == LT - 1) m_lp = 1;
      if (m_held < LT) m_held++;
    end
    m_btn_s = pb;
    m_db = new_db;
    m_ir_prev = ir;
  endtask

  task automatic step(input bit r, input bit c);
    rst = r; push_button = pb_lvl; infravermelho = ir_lvl; C = c;
    @(posedge clk);
    model_edge(r, pb_lvl, ir_lvl, c);
    exp_q.push_back({m_lamp, (!m_manual && m_lamp), m_manual});
    @(negedge clk);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic press(input int n);
    pb_lvl = 1; cyc(n);
    pb_lvl = 0; cyc(DT + 3);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({lamp, enable, manual} !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got lamp/enable/manual=%b%b%b want %b", $time,
                 lamp, enable, manual, e);
      end
    end
  end

  initial begin
    int guard;
    model_reset();
    pb_lvl = 0; ir_lvl = 0;
    rst = 1; push_button = 0; infravermelho = 0; C = 0;
    @(negedge clk);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    cyc(3);

    // 1: presence lights, C shuts off, steady presence does not re-light
    ir_lvl = 1; cyc(2);
    step(1'b0, 1'b1);
    cyc(50);

    // 2: bouncing press then clean release -> single short press
    pb_lvl = 1; cyc(1); pb_lvl = 0; cyc(1); pb_lvl = 1; cyc(8);
    pb_lvl = 0; cyc(12);

    // 3: long hold from AUTO_ON -> MANUAL_ON; C and new presence ignored
    press(30);
    cyc(5);
    step(1'b0, 1'b1);
    ir_lvl = 0; cyc(2); ir_lvl = 1; cyc(5);

    // 4a: back to AUTO_ON, then short press coinciding with C
    press(30);
    pb_lvl = 1; cyc(6); pb_lvl = 0;
    guard = 0;
    while (!m_sp && guard < 50) begin cyc(1); guard++; end
    step(1'b0, 1'b1);
    cyc(8);
    // 4b: long press coinciding with a presence rising edge in AUTO_OFF
    ir_lvl = 0; pb_lvl = 1;
    guard = 0;
    while (!m_lp && guard < 60) begin cyc(1); guard++; end
    ir_lvl = 1; cyc(1);
    pb_lvl = 0; cyc(10);

    // 5: reset in the middle of a held press, then release
    press(30);
    ir_lvl = 0; cyc(3);
    pb_lvl = 1; cyc(10);
    step(1'b1, 1'b0);
    cyc(1); pb_lvl = 0; cyc(15);

    // 6: long press to MANUAL_OFF, long press back to AUTO_OFF, presence lights
    press(30);
    press(30);
    ir_lvl = 1; cyc(4);

    // random traffic
    for (int k = 0; k < 250; k++) begin
      case ($urandom_range(0, 9))
        0, 1: press($urandom_range(1, 35));
        2: begin
          for (int b = 0; b < 3; b++) begin pb_lvl = ~pb_lvl; cyc($urandom_range(1, 3)); end
          pb_lvl = 0; cyc(DT + 2);
        end
        3, 4: begin ir_lvl = ~ir_lvl; cyc($urandom_range(1, 6)); end
        5, 6: begin step(1'b0, 1'b1); cyc($urandom_range(0, 4)); end
        7: step(1'b0, $urandom_range(0, 1) == 1);
        8: begin pb_lvl = $urandom_range(0, 1) == 1; step(1'b1, 1'b0); end
        default: cyc($urandom_range(1, 10));
      endcase
    end
    pb_lvl = 0; cyc(30);

    done = 1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
